// File: rtl/p405s_icu_regarbfill.sv
// p405s_icu_regarbfill: arbitrates the ICU address register between fill, cache-op and fetch, and sequences critical-word-first line fills
module p405s_icu_regarbfill #(
  parameter int LINE_WORDS   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CB,
  input  logic        Reset,
  input  logic        fetchReq,
  input  logic [0:31] fetchAddr,
  input  logic        cacheOpReq,
  input  logic [0:31] cacheOpAddr,
  input  logic        fillReq,
  input  logic [0:31] fillAddr,
  input  logic        fillBeatVal,
  output logic [0:31] regD,
  output logic        regE1,
  output logic        fetchGnt,
  output logic        cacheOpGnt,
  output logic        fillGnt,
  output logic        fillBusy,
  output logic        fillDone
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t        state_q, state_d;
  logic [2:0]    beat_cnt_q, beat_cnt_d, crit_idx_q, crit_idx_d, word_idx;
  logic [0:26]   line_base_q, line_base_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          idle, starved, beat, last;
  always_ff @(posedge CB) begin
    if (Reset) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      crit_idx_q   <= '0;
      line_base_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      crit_idx_q   <= crit_idx_d;
      line_base_q  <= line_base_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
  always_comb begin
    state_d      = fillGnt ? FILL : fillDone ? IDLE : state_q;
    beat_cnt_d   = fillGnt ? '0 : beat ? beat_cnt_q + 3'd1 : beat_cnt_q;
    crit_idx_d   = fillGnt ? fillAddr[27:29] : crit_idx_q;
    line_base_d  = fillGnt ? fillAddr[0:26] : line_base_q;
    starve_cnt_d = (!fetchReq || fetchGnt) ? '0 :
                   (state_q == FILL || starved) ? starve_cnt_q : starve_cnt_q + SW'(1);
  end
  always_comb begin
    idle       = !Reset && state_q == IDLE;
    starved    = starve_cnt_q == SW'(STARVE_LIMIT);
    beat       = !Reset && state_q == FILL && fillBeatVal;
    last       = beat_cnt_q == 3'(LINE_WORDS - 1);
    word_idx   = crit_idx_q + beat_cnt_q + 3'd1;
    fillGnt    = idle && fillReq;
    fetchGnt   = idle && !fillReq && fetchReq && (starved || !cacheOpReq);
    cacheOpGnt = idle && !fillReq && cacheOpReq && !(fetchReq && starved);
    fillDone   = beat && last;
    regE1      = fillGnt || fetchGnt || cacheOpGnt || (beat && !last);
    regD       = (fillGnt || fetchGnt || cacheOpGnt) ?
                 (fillGnt ? fillAddr : fetchGnt ? fetchAddr : cacheOpAddr) & 32'hFFFF_FFFC :
                 (beat && !last) ? {line_base_q, word_idx, 2'b00} : '0;
  end
  assign fillBusy = state_q == FILL;
endmodule

// File: tb/tb_p405s_icu_regarbfill.sv
// tb_p405s_icu_regarbfill: directed and randomized checks of the register arbiter against a queue-based reference model
module tb_p405s_icu_regarbfill;
  localparam int SL = 4;
  logic        CB = 0, Reset = 1, fetchReq = 0, cacheOpReq = 0, fillReq = 0, fillBeatVal = 0;
  logic [31:0] fetchAddr = 0, cacheOpAddr = 0, fillAddr = 0, regD;
  logic        regE1, fetchGnt, cacheOpGnt, fillGnt, fillBusy, fillDone;
  int          n_cmp = 0, n_err = 0;
  bit          m_fill = 0;
  int          m_starve = 0;
  logic [31:0] fq[$];
  logic [2:0]  e_gnt;
  logic        e_e1, e_done;
  logic [31:0] e_d;
  p405s_icu_regarbfill #(.LINE_WORDS(8), .STARVE_LIMIT(SL)) dut (
    .CB(CB), .Reset(Reset), .fetchReq(fetchReq), .fetchAddr(fetchAddr),
    .cacheOpReq(cacheOpReq), .cacheOpAddr(cacheOpAddr), .fillReq(fillReq),
    .fillAddr(fillAddr), .fillBeatVal(fillBeatVal), .regD(regD), .regE1(regE1),
    .fetchGnt(fetchGnt), .cacheOpGnt(cacheOpGnt), .fillGnt(fillGnt),
    .fillBusy(fillBusy), .fillDone(fillDone)
  );
  always #5 CB = ~CB;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic settle();
    @(negedge CB);
    e_gnt = 0; e_e1 = 0; e_done = 0; e_d = 0;
    if (!Reset) begin
      if (!m_fill) begin
        if (fillReq) begin e_gnt = 3'b100; e_d = fillAddr; end
        else if (fetchReq && m_starve >= SL) begin e_gnt = 3'b001; e_d = fetchAddr; end
        else if (cacheOpReq) begin e_gnt = 3'b010; e_d = cacheOpAddr; end
        else if (fetchReq) begin e_gnt = 3'b001; e_d = fetchAddr; end
        e_d = e_d & ~32'h3;
        e_e1 = |e_gnt;
      end else if (fillBeatVal) begin
        if (fq.size() != 0) begin e_e1 = 1; e_d = fq[0]; end
        else e_done = 1;
      end
    end
    chk("grants", 32'({fillGnt, cacheOpGnt, fetchGnt}), 32'(e_gnt));
    chk("regE1", 32'(regE1), 32'(e_e1));
    chk("regD", regD, e_d);
    chk("fillDone", 32'(fillDone), 32'(e_done));
    chk("fillBusy", 32'(fillBusy), 32'(m_fill));
  endtask
  task automatic advance();
    @(posedge CB);
    if (Reset) begin
      m_fill = 0; m_starve = 0; fq.delete();
    end else begin
      if (!fetchReq || e_gnt[0]) m_starve = 0;
      else if (!m_fill && m_starve < SL) m_starve++;
      if (e_gnt[2]) begin
        m_fill = 1;
        for (int k = 1; k < 8; k++)
          fq.push_back({fillAddr[31:5], 5'b0} | 32'(((int'(fillAddr[4:2]) + k) % 8) * 4));
      end else if (m_fill && fillBeatVal) begin
        if (fq.size() != 0) void'(fq.pop_front());
        else m_fill = 0;
      end
    end
    #1;
  endtask
  task automatic tick();
    settle();
    advance();
  endtask
  initial begin
    logic [31:0] wrap_exp [7];
    wrap_exp = '{32'h1038, 32'h103C, 32'h1020, 32'h1024, 32'h1028, 32'h102C, 32'h1030};
    fetchReq = 1; cacheOpReq = 1; fillReq = 1; fillBeatVal = 1;
    fetchAddr = 32'h0000_2007; cacheOpAddr = 32'h3000; fillAddr = 32'h7000;
    advance();
    settle();
    chk("rst_regD", regD, 0);
    chk("rst_busy", 32'(fillBusy), 0);
    advance();
    Reset = 0; cacheOpReq = 0; fillReq = 0; fillBeatVal = 0;
    settle();
    chk("rel_fetchGnt", 32'(fetchGnt), 1);
    chk("rel_regD", regD, 32'h0000_2004);
    advance();
    fetchReq = 0; fillReq = 1; fillAddr = 32'h0000_1034;
    settle();
    chk("wrap_grant_regD", regD, 32'h1034);
    advance();
    fillReq = 0; fillBeatVal = 1;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (i < 7) chk("wrap_beat_regD", regD, wrap_exp[i]);
      else begin
        chk("wrap_done", 32'(fillDone), 1);
        chk("wrap_done_e1", 32'(regE1), 0);
      end
      chk("wrap_busy", 32'(fillBusy), 1);
      advance();
    end
    fillBeatVal = 0;
    settle();
    chk("wrap_busy_end", 32'(fillBusy), 0);
    advance();
    fillReq = 1; cacheOpReq = 1; fetchReq = 1;
    fillAddr = 32'h4000; cacheOpAddr = 32'h5008; fetchAddr = 32'h6010;
    settle();
    chk("prio_fill", 32'({fillGnt, cacheOpGnt, fetchGnt}), 32'b100);
    advance();
    fillReq = 0; fillBeatVal = 1;
    repeat (8) tick();
    fillBeatVal = 0;
    settle();
    chk("prio_cacheop", 32'(cacheOpGnt), 1);
    advance();
    cacheOpReq = 0;
    settle();
    chk("prio_fetch", 32'(fetchGnt), 1);
    advance();
    cacheOpReq = 1; fetchReq = 1;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk("starve_fetch", 32'(fetchGnt), (i == 4) ? 1 : 0);
      chk("starve_cacheop", 32'(cacheOpGnt), (i == 4) ? 0 : 1);
      advance();
    end
    cacheOpReq = 0; fetchReq = 0; fillReq = 1; fillBeatVal = 1; fillAddr = 32'h0008_00FC;
    tick();
    fillReq = 0; fetchReq = 1;
    for (int i = 0; i < 16; i++) begin
      fillBeatVal = i[0];
      settle();
      chk("gap_no_fetch", 32'(fetchGnt), 0);
      if (i < 15) chk("gap_e1", 32'(regE1), 32'(fillBeatVal));
      advance();
    end
    fillBeatVal = 0;
    settle();
    chk("gap_fetch_after", 32'(fetchGnt), 1);
    advance();
    fetchReq = 0; fillReq = 1; fillAddr = 32'h0000_9A5C;
    tick();
    fillReq = 0; fillBeatVal = 1;
    repeat (4) tick();
    Reset = 1;
    settle();
    chk("rstmid_done", 32'(fillDone), 0);
    chk("rstmid_e1", 32'(regE1), 0);
    advance();
    Reset = 0; fillBeatVal = 0; fetchReq = 1; fetchAddr = 32'hABCD_0002;
    settle();
    chk("rstmid_busy", 32'(fillBusy), 0);
    chk("rstmid_fetch", 32'(fetchGnt), 1);
    advance();
    for (int i = 0; i < 3000; i++) begin
      Reset       = ($urandom_range(199) == 0);
      fillReq     = ($urandom_range(5) == 0);
      cacheOpReq  = $urandom_range(1);
      fetchReq    = ($urandom_range(3) != 0);
      fillBeatVal = ($urandom_range(2) != 0);
      fetchAddr   = $urandom;
      cacheOpAddr = $urandom;
      fillAddr    = $urandom;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
